// File: rtl/systolic_mm_top_if.sv
// Bank read-data, partial-sum and result bus of the systolic matrix-multiply engine.
// master = engine side, slave = memory/stimulus side.
interface systolic_mm_top_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned M      = 8,
    parameter int unsigned ADDR_W = 10
);
    logic [M*DATA_W-1:0]  MemOutputA0;
    logic [M*DATA_W-1:0]  MemOutputA1;
    logic [M*DATA_W-1:0]  MemOutputA2;
    logic [M*DATA_W-1:0]  MemOutputA3;
    logic [16*DATA_W-1:0] MemOutputB;
    logic [DATA_W-1:0]    ipPsum;
    logic [DATA_W-1:0]    OpC30;
    logic [DATA_W-1:0]    OpC31;
    logic [DATA_W-1:0]    OpC32;
    logic [DATA_W-1:0]    OpC33;
    logic [ADDR_W-1:0]    BankAddr;
    logic                 start_check;

    modport master (
        input  MemOutputA0, MemOutputA1, MemOutputA2, MemOutputA3, MemOutputB, ipPsum,
        output OpC30, OpC31, OpC32, OpC33, BankAddr, start_check
    );

    modport slave (
        output MemOutputA0, MemOutputA1, MemOutputA2, MemOutputA3, MemOutputB, ipPsum,
        input  OpC30, OpC31, OpC32, OpC33, BankAddr, start_check
    );
endinterface

// File: rtl/systolic_mm_top.sv
// 4x4 weight-stationary systolic engine: each 17-cycle case computes C(8x4) = A(8x4) x B + ipPsum.
// Define SYSTOLIC_SAT_EN for signed 32-bit saturating accumulation (default: modulo-2^32 wrap).
module systolic_mm_top #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned N           = 4,
    parameter int unsigned M           = 8,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned NUM_CASES   = 1024,
    parameter int unsigned CASE_CYCLES = 17
) (
    input logic               clk,
    input logic               rstSys,
    input logic               startSys,
    systolic_mm_top_if.master bus
);
    localparam int unsigned PH_W = $clog2(CASE_CYCLES);
    localparam logic [PH_W-1:0] PH_LOAD     = PH_W'(1);
    localparam logic [PH_W-1:0] PH_OUT0     = PH_W'(2 * N - 1);
    localparam logic [PH_W-1:0] PH_OUT_LAST = PH_W'(2 * N - 1 + M - 1);
    localparam logic [PH_W-1:0] PH_LAST     = PH_W'(CASE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_CASES - 1);

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [2*DATA_W+1:0] SAT_MAX = {{(DATA_W+3){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W+1:0] SAT_MIN = {{(DATA_W+3){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    function automatic logic [DATA_W-1:0] mac(input logic [DATA_W-1:0] psum,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] w);
`ifdef SYSTOLIC_SAT_EN
        logic signed [2*DATA_W+1:0] v_sum;
        v_sum = $signed({{(DATA_W+2){psum[DATA_W-1]}}, psum}) + ($signed(a) * $signed(w));
        if (v_sum > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (v_sum < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end
        return v_sum[DATA_W-1:0];
`else
        return psum + a * w;
`endif
    endfunction

    logic [PH_W-1:0]     r_phase;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_start_check;
    logic [DATA_W-1:0]   r_w     [N][N];
    logic [M*DATA_W-1:0] r_abuf  [N];
    logic [DATA_W-1:0]   r_a     [N][N-1];
    logic [DATA_W-1:0]   r_psum  [N-1][N];

    logic [M*DATA_W-1:0] w_bank_a  [N];
    logic [DATA_W-1:0]   w_a_in    [N];
    logic [DATA_W-1:0]   w_w_eff   [N][N];
    logic [DATA_W-1:0]   w_a_pe    [N][N];
    logic [DATA_W-1:0]   w_psum_pe [N][N];
    logic [DATA_W-1:0]   w_sum     [N][N];
    logic [DATA_W-1:0]   w_col     [N];
    logic                w_clr;
    logic                w_out_en;
    int                  w_off;

    assign w_bank_a[0] = bus.MemOutputA0;
    assign w_bank_a[1] = bus.MemOutputA1;
    assign w_bank_a[2] = bus.MemOutputA2;
    assign w_bank_a[3] = bus.MemOutputA3;

    assign w_clr    = rstSys | ~startSys | (r_phase == '0);
    assign w_out_en = (r_phase >= PH_OUT0) && (r_phase <= PH_OUT_LAST);

    // Case sequencer: phase 0..16 per case, address advances on the last phase.
    always_ff @(posedge clk) begin
        if (rstSys || !startSys) begin
            r_phase       <= '0;
            r_addr        <= '0;
            r_start_check <= 1'b0;
        end else begin
            r_start_check <= (r_phase == PH_OUT0 - PH_W'(1));
            if (r_phase == PH_LAST) begin
                r_phase <= '0;
                r_addr  <= (r_addr == ADDR_LAST) ? '0 : r_addr + ADDR_W'(1);
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstSys) begin
            for (int k = 0; k < N; k++) begin
                r_abuf[k] <= '0;
                for (int j = 0; j < N; j++) begin
                    r_w[k][j] <= '0;
                end
            end
        end else if (startSys && (r_phase == PH_LOAD)) begin
            for (int k = 0; k < N; k++) begin
                r_abuf[k] <= w_bank_a[k];
                for (int j = 0; j < N; j++) begin
                    r_w[k][j] <= bus.MemOutputB[DATA_W*(N*k+j) +: DATA_W];
                end
            end
        end
    end

    // Skewed feed: row r of A reaches array row k in phase 1+r+k. Element (0,0) is used in the
    // load phase itself, straight from the bank, before the buffers hold it.
    always_comb begin
        w_off = 0;
        for (int k = 0; k < N; k++) begin
            w_a_in[k] = '0;
            w_off     = int'(r_phase) - int'(PH_LOAD) - k;
            if (w_off == 0 && k == 0) begin
                w_a_in[k] = w_bank_a[0][DATA_W-1:0];
            end else if (w_off >= 0 && w_off < int'(M)) begin
                w_a_in[k] = r_abuf[k][w_off*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign w_w_eff[k][j] = (r_phase == PH_LOAD) ?
                                   bus.MemOutputB[DATA_W*(N*k+j) +: DATA_W] : r_w[k][j];
            if (j == 0) begin : g_a_edge
                assign w_a_pe[k][j] = w_a_in[k];
            end else begin : g_a_link
                assign w_a_pe[k][j] = r_a[k][j-1];
            end
            if (k == 0) begin : g_p_edge
                assign w_psum_pe[k][j] = bus.ipPsum;
            end else begin : g_p_link
                assign w_psum_pe[k][j] = r_psum[k-1][j];
            end
            assign w_sum[k][j] = mac(w_psum_pe[k][j], w_a_pe[k][j], w_w_eff[k][j]);
        end
    end

    // The bottom row's sum is consumed directly by the deskew stage, so only rows 0..N-2 are
    // registered vertically.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N - 1; j++) begin
                r_a[k][j] <= w_clr ? '0 : w_a_pe[k][j];
            end
        end
        for (int k = 0; k < N - 1; k++) begin
            for (int j = 0; j < N; j++) begin
                r_psum[k][j] <= w_clr ? '0 : w_sum[k][j];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_dsk
        localparam int unsigned DEPTH = N - 1 - j;
        if (DEPTH == 0) begin : g_pass
            assign w_col[j] = w_sum[N-1][j];
        end else begin : g_pipe
            logic [DATA_W-1:0] r_pipe [DEPTH];
            always_ff @(posedge clk) begin
                if (w_clr) begin
                    for (int d = 0; d < DEPTH; d++) begin
                        r_pipe[d] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_sum[N-1][j];
                    for (int d = 1; d < DEPTH; d++) begin
                        r_pipe[d] <= r_pipe[d-1];
                    end
                end
            end
            assign w_col[j] = r_pipe[DEPTH-1];
        end
    end

    assign bus.OpC30       = w_out_en ? w_col[0] : '0;
    assign bus.OpC31       = w_out_en ? w_col[1] : '0;
    assign bus.OpC32       = w_out_en ? w_col[2] : '0;
    assign bus.OpC33       = w_out_en ? w_col[3] : '0;
    assign bus.BankAddr    = r_addr;
    assign bus.start_check = r_start_check;
endmodule

// File: tb/tb_systolic_mm_top.sv
// Randomized and directed bench for systolic_mm_top against a plain-arithmetic matrix model.
module tb_systolic_mm_top;
    localparam int CC = 17;
    localparam int NC = 1024;

    logic clk = 1'b0;
    logic rstSys;
    logic startSys;
    int   checks   = 0;
    int   failures = 0;

    logic [255:0] mem_a [4][NC];
    logic [511:0] mem_b [NC];

    systolic_mm_top_if bus ();

    systolic_mm_top dut (
        .clk      (clk),
        .rstSys   (rstSys),
        .startSys (startSys),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Synchronous banks: one-cycle read latency on the shared address.
    always @(posedge clk) begin
        bus.MemOutputA0 <= mem_a[0][bus.BankAddr];
        bus.MemOutputA1 <= mem_a[1][bus.BankAddr];
        bus.MemOutputA2 <= mem_a[2][bus.BankAddr];
        bus.MemOutputA3 <= mem_a[3][bus.BankAddr];
        bus.MemOutputB  <= mem_b[bus.BankAddr];
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_c(int addr, int r, int j);
        logic [31:0] a;
        logic [31:0] b;
`ifdef SYSTOLIC_SAT_EN
        longint acc;
        acc = longint'($signed(bus.ipPsum));
        for (int k = 0; k < 4; k++) begin
            a   = mem_a[k][addr][32*r +: 32];
            b   = mem_b[addr][32*(4*k+j) +: 32];
            acc = acc + longint'($signed(a)) * longint'($signed(b));
            if (acc > 64'sd2147483647) acc = 64'sd2147483647;
            if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        end
        return acc[31:0];
`else
        logic [31:0] acc;
        acc = bus.ipPsum;
        for (int k = 0; k < 4; k++) begin
            a   = mem_a[k][addr][32*r +: 32];
            b   = mem_b[addr][32*(4*k+j) +: 32];
            acc = acc + a * b;
        end
        return acc;
`endif
    endfunction

    function automatic logic [127:0] model_row(int addr, int r);
        logic [127:0] row;
        for (int j = 0; j < 4; j++) row[32*(3-j) +: 32] = model_c(addr, r, j);
        return row;
    endfunction

    function automatic logic [127:0] opc_row();
        return {bus.OpC30, bus.OpC31, bus.OpC32, bus.OpC33};
    endfunction

    // n counts cycles from the first running cycle (phase 0 of case 0).
    task automatic check_cycle(input int n);
        int cs;
        int ph;
        logic [127:0] exp_row;
        cs = (n / CC) % NC;
        ph = n % CC;
        exp_row = (ph >= 7 && ph <= 14) ? model_row(cs, ph - 7) : '0;
        check_eq($sformatf("opc n=%0d", n), opc_row(), exp_row);
        check_eq($sformatf("addr n=%0d", n), 128'(bus.BankAddr), 128'(cs));
        check_eq($sformatf("start_check n=%0d", n), 128'(bus.start_check), 128'(ph == 7));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " opc"}, opc_row(), '0);
        check_eq({tag, " addr"}, 128'(bus.BankAddr), '0);
        check_eq({tag, " start_check"}, 128'(bus.start_check), '0);
    endtask

    // Called #1 after an edge with phase known to be 0.
    task automatic run_cycles(input int ncyc);
        rstSys   = 1'b0;
        startSys = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            check_cycle(n);
        end
    endtask

    task automatic stop_run(input string tag);
        startSys = 1'b0;
        @(posedge clk);
        #1;
        check_idle(tag);
    endtask

    task automatic fill_random();
        for (int ad = 0; ad < NC; ad++) begin
            for (int k = 0; k < 4; k++)
                for (int r = 0; r < 8; r++) mem_a[k][ad][32*r +: 32] = $urandom();
            for (int e = 0; e < 16; e++) mem_b[ad][32*e +: 32] = $urandom();
        end
    endtask

    task automatic fill_case0(input int a_mode, input int b_mode);
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 8; r++) begin
                case (a_mode)
                    0:       mem_a[k][0][32*r +: 32] = 32'd1;
                    1:       mem_a[k][0][32*r +: 32] = 32'(r);
                    default: mem_a[k][0][32*r +: 32] = 32'h7FFF_FFFF;
                endcase
            end
            for (int j = 0; j < 4; j++) begin
                case (b_mode)
                    0:       mem_b[0][32*(4*k+j) +: 32] = (k == j) ? 32'd1 : 32'd0;
                    1:       mem_b[0][32*(4*k+j) +: 32] = 32'(j + 1);
                    default: mem_b[0][32*(4*k+j) +: 32] = 32'd2;
                endcase
            end
        end
    endtask

    initial begin
        logic [31:0] sat_exp;
        rstSys     = 1'b1;
        startSys   = 1'b1;
        bus.ipPsum = $urandom();
        fill_random();

        // Reset held two cycles with the run enable already high.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("reset%0d", i));
        end
        run_cycles(2 * CC);
        stop_run("after_reset_run");

        // A all ones, B identity.
        bus.ipPsum = 32'd0;
        fill_case0(0, 0);
        run_cycles(CC);
        stop_run("ones");

        // A row r = r, B(k,j) = j+1, ipPsum = 5.
        bus.ipPsum = 32'd5;
        fill_case0(1, 1);
        run_cycles(15);
        check_eq("ramp_row7", opc_row(), {32'd33, 32'd61, 32'd89, 32'd117});
        stop_run("ramp");

        // Overflowing accumulation.
        bus.ipPsum = 32'd0;
        fill_case0(2, 2);
        run_cycles(8);
`ifdef SYSTOLIC_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'hFFFF_FFF8;
`endif
        check_eq("overflow_c00", 128'(bus.OpC30), 128'(sat_exp));
        stop_run("overflow");

        // Full random sweep including the 1023 -> 0 wrap.
        fill_random();
        bus.ipPsum = $urandom();
        run_cycles(CC * NC + CC);
        check_eq("wrap_addr", 128'(bus.BankAddr), '0);
        stop_run("sweep");

        // Drop the run enable in phase 10 of case 3, then restart.
        run_cycles(3 * CC + 11);
        stop_run("drop");
        @(posedge clk);
        #1;
        run_cycles(CC);
        stop_run("restart");

        // Synchronous reset in the middle of a case.
        run_cycles(CC + 9);
        rstSys = 1'b1;
        @(posedge clk);
        #1;
        check_idle("mid_reset");
        run_cycles(CC);
        stop_run("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
